// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the display request scheduler.
// Holds the FSM state type, display constants and the round-robin pick helper.
package display_scheduler_pkg;

  localparam int NUM_REQ = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_HOLD,
    S_RELEASE
  } sched_state_t;

  // First set bit of req searching upward from last+1, wrapping mod 8.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [2:0]         last);
    logic [2:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last + 3'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/convert_hex_to_seven_segment.sv
// 4-bit hex to active-low seven-segment decoder (segment order gfedcba).
module convert_hex_to_seven_segment
  import display_scheduler_pkg::*;
(
  input  logic [3:0] hex_value,
  output logic [6:0] segment_n
);

  always_comb begin
    // NOTE: default assigned first so no path through the case can infer a latch.
    segment_n = SEG_BLANK;
    case (hex_value)
      4'h0: segment_n = 7'h40;
      4'h1: segment_n = 7'h79;
      4'h2: segment_n = 7'h24;
      4'h3: segment_n = 7'h30;
      4'h4: segment_n = 7'h19;
      4'h5: segment_n = 7'h12;
      4'h6: segment_n = 7'h02;
      4'h7: segment_n = 7'h78;
      4'h8: segment_n = 7'h00;
      4'h9: segment_n = 7'h10;
      4'hA: segment_n = 7'h08;
      4'hB: segment_n = 7'h03;
      4'hC: segment_n = 7'h46;
      4'hD: segment_n = 7'h21;
      4'hE: segment_n = 7'h06;
      4'hF: segment_n = 7'h0E;
      default: segment_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_request_scheduler.sv
// Round-robin scheduler sharing digit 0 and the LEDs among eight switch requesters.
// Optional switch debounce is enabled by defining DISPLAY_SCHED_DEBOUNCE_EN.
module display_request_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic            CLOCK_50_I,
  input  logic            RESETN_I,
  input  logic [17:0]     SWITCH_I,
  output logic [7:0][6:0] SEVEN_SEGMENT_N_O,
  output logic [17:0]     LED_RED_O,
  output logic [8:0]      LED_GREEN_O
);

  localparam int unsigned       HOLD_W    = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 2);

  if (HOLD_CYCLES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("display_request_scheduler: HOLD_CYCLES must be >= 2, DEBOUNCE_CYCLES >= 1");
  end

  logic [17:0] sw_meta;
  logic [17:0] sw_sync;
  logic [17:0] sw_clean;

  always_ff @(posedge CLOCK_50_I) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RESETN_I) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SWITCH_I;
      sw_sync <= sw_meta;
    end
  end

`ifdef DISPLAY_SCHED_DEBOUNCE_EN
  localparam int unsigned      DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [DEB_W-1:0] deb_cnt [18];

  // A bit's clean value follows its synchronized input only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge CLOCK_50_I) begin
    // NOTE: the counter array is small register state, so it is reset like any
    // other flop; a large RAM-style array would be left unreset instead.
    if (!RESETN_I) begin
      sw_clean <= '0;
      for (int b = 0; b < 18; b++) deb_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 18; b++) begin
        if (sw_sync[b] == sw_clean[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DEB_LAST) begin
          sw_clean[b] <= sw_sync[b];
          deb_cnt[b]  <= '0;
        end else begin
          deb_cnt[b] <= deb_cnt[b] + DEB_W'(1);
        end
      end
    end
  end
`else
  assign sw_clean = sw_sync;
`endif

  logic               clear_req;
  logic               enable;
  logic [NUM_REQ-1:0] req_prev;
  logic [NUM_REQ-1:0] req_rise;
  logic               unused_sw;

  assign clear_req = sw_clean[16];
  assign enable    = sw_clean[17];
  assign req_rise  = sw_clean[NUM_REQ-1:0] & ~req_prev;
  assign unused_sw = ^sw_clean[15:8];

  sched_state_t       state, state_next;
  logic [NUM_REQ-1:0] grant, grant_next;
  logic [NUM_REQ-1:0] pending, pending_next, pend_drop;
  logic               busy;
  logic [2:0]         last_grant;
  logic [2:0]         winner;
  logic               granted_once;
  logic               launch;
  logic [7:0]         service_count;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               hold_done;

  assign winner    = rr_pick(pending, last_grant);
  assign hold_done = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_next = state;
    grant_next = grant;
    launch     = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && (|pending)) begin
          state_next = S_GRANT;
          grant_next = 8'b1 << winner;
          launch     = 1'b1;
        end
      end
      S_GRANT:   state_next = S_HOLD;
      S_HOLD: begin
        if (hold_done) begin
          state_next = S_RELEASE;
          grant_next = '0;
        end
      end
      S_RELEASE: state_next = S_IDLE;
      default: begin
        state_next = S_IDLE;
        grant_next = '0;
      end
    endcase
  end

  // The winner's pending bit drops at the end of S_GRANT; a new edge that same
  // cycle, or alongside a clear, keeps the bit set.
  always_comb begin
    pend_drop = '0;
    if (clear_req)              pend_drop = '1;
    else if (state == S_GRANT)  pend_drop = grant;
    pending_next = (pending & ~pend_drop) | req_rise;
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (!RESETN_I) begin
      state         <= S_IDLE;
      grant         <= '0;
      busy          <= 1'b0;
      pending       <= '0;
      req_prev      <= '0;
      last_grant    <= 3'(NUM_REQ - 1);
      granted_once  <= 1'b0;
      service_count <= '0;
      hold_cnt      <= '0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      busy     <= (state_next != S_IDLE);
      pending  <= pending_next;
      req_prev <= sw_clean[NUM_REQ-1:0];
      if (launch) begin
        last_grant    <= winner;
        granted_once  <= 1'b1;
        service_count <= service_count + 8'd1;
      end
      if (state == S_HOLD) hold_cnt <= hold_cnt + HOLD_W'(1);
      else                 hold_cnt <= '0;
    end
  end

  assign LED_RED_O   = {10'b0, pending};
  assign LED_GREEN_O = {busy, grant};

  logic [6:0] seg_grant, seg_last, seg_cnt_lo, seg_cnt_hi;

  convert_hex_to_seven_segment u_digit0 (.hex_value({1'b0, last_grant}),  .segment_n(seg_grant));
  convert_hex_to_seven_segment u_digit1 (.hex_value({1'b0, last_grant}),  .segment_n(seg_last));
  convert_hex_to_seven_segment u_digit2 (.hex_value(service_count[3:0]),  .segment_n(seg_cnt_lo));
  convert_hex_to_seven_segment u_digit3 (.hex_value(service_count[7:4]),  .segment_n(seg_cnt_hi));

  // last_grant always equals the active grant index while a grant is held.
  always_comb begin
    for (int d = 0; d < 8; d++) SEVEN_SEGMENT_N_O[d] = SEG_BLANK;
    if (|grant)       SEVEN_SEGMENT_N_O[0] = seg_grant;
    if (granted_once) SEVEN_SEGMENT_N_O[1] = seg_last;
    SEVEN_SEGMENT_N_O[2] = seg_cnt_lo;
    SEVEN_SEGMENT_N_O[3] = seg_cnt_hi;
  end

endmodule

// File: tb/tb_display_request_scheduler.sv
// Directed self-checking bench for display_request_scheduler with HOLD_CYCLES=4.
module tb_display_request_scheduler;

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] H0 = 7'h40;
  localparam logic [6:0] H1 = 7'h79;
  localparam logic [6:0] H2 = 7'h24;
  localparam logic [6:0] H3 = 7'h30;
  localparam logic [6:0] H7 = 7'h78;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [17:0]     sw = '0;
  logic [7:0][6:0] seg_n;
  logic [17:0]     led_red;
  logic [8:0]      led_green;

  int vectors = 0;
  int miscompares = 0;

  display_request_scheduler #(.HOLD_CYCLES(4), .DEBOUNCE_CYCLES(2)) dut (
    .CLOCK_50_I       (clk),
    .RESETN_I         (rst_n),
    .SWITCH_I         (sw),
    .SEVEN_SEGMENT_N_O(seg_n),
    .LED_RED_O        (led_red),
    .LED_GREEN_O      (led_green)
  );

  always #5 clk = ~clk;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [6:0] hex7(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      default: return BL;
    endcase
  endfunction

  function automatic logic [55:0] disp(input logic [6:0] d3, d2, d1, d0);
    return {BL, BL, BL, BL, d3, d2, d1, d0};
  endfunction

  // Entered on the S_GRANT cycle; leaves on the cycle after the idle gap.
  task automatic grant_window(input string tag, input int idx);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("%s_grant%0d", tag, c), led_green, 9'h100 | (9'h1 << idx));
      check($sformatf("%s_dig0_%0d", tag, c), seg_n[0], hex7(idx));
      step();
    end
    check($sformatf("%s_release", tag), led_green, 9'h100);
    step();
    check($sformatf("%s_idle", tag), led_green, 9'h000);
    step();
  endtask

  task automatic wait_grant(input string tag, input int budget);
    int n = 0;
    while (led_green[7:0] == 8'h00 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_arrived"}, (n < budget), 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sw    = '0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with arbitrary switches
    rst_n = 1'b0;
    sw    = 18'h3FFFF;
    step(3);
    check("rst_red",   led_red,   18'h0);
    check("rst_green", led_green, 9'h0);
    check("rst_seg",   seg_n,     disp(H0, H0, BL, BL));
    sw    = '0;
    rst_n = 1'b1;
    step();

    // Single request on 2
    sw = 18'h20000;
    step(3);
    sw = 18'h20004;
    step(3);
    check("single_pending", led_red,   18'h004);
    check("single_nogrant", led_green, 9'h000);
    step();
    check("single_pend_in_grant", led_red, 18'h004);
    check("single_seg_grant",     seg_n,   disp(H0, H1, H2, H2));
    grant_window("single", 2);
    check("single_pend_after", led_red, 18'h000);
    check("single_seg_after",  seg_n,   disp(H0, H1, H2, BL));

    // Round-robin 0,1,7 from a fresh reset
    do_reset();
    sw = 18'h20000;
    step(3);
    sw = 18'h20083;
    step(3);
    check("rr_pending", led_red, 18'h083);
    step();
    grant_window("rr_0", 0);
    grant_window("rr_1", 1);
    grant_window("rr_7", 7);
    check("rr_pend_after", led_red,   18'h000);
    check("rr_green_after", led_green, 9'h000);
    check("rr_seg_after",  seg_n,     disp(H0, H3, H7, BL));

    // Enable off, then clear pulse, then enable with no new edges
    sw = 18'h00000;
    step(3);
    sw = 18'h00028;
    step(3);
    check("dis_pending", led_red, 18'h028);
    step(5);
    check("dis_nogrant", led_green, 9'h000);
    check("dis_pending_held", led_red, 18'h028);
    sw = 18'h10028;
    step();
    sw = 18'h00028;
    step(3);
    check("clr_pending", led_red, 18'h000);
    sw = 18'h20028;
    step(6);
    check("en_nogrant", led_green, 9'h000);
    check("en_nopend",  led_red,   18'h000);

    // Request 1 re-edges during its own S_GRANT cycle
    do_reset();
    sw = 18'h20000;
    step(3);
    sw = 18'h20012;
    step();
    sw = 18'h20010;
    step();
    sw = 18'h20012;
    step();
    check("reedge_pending", led_red, 18'h012);
    step();
    check("reedge_pend_in_grant", led_red, 18'h012);
    grant_window("reedge_1a", 1);
    check("reedge_pend_kept", led_red, 18'h012);
    grant_window("reedge_4", 4);
    check("reedge_pend_1only", led_red, 18'h002);
    grant_window("reedge_1b", 1);
    check("reedge_pend_done", led_red, 18'h000);
    check("reedge_seg",       seg_n,   disp(H0, H3, H1, BL));

    // Clear pulse coinciding with a new edge on 6 (2 already pending)
    sw = 18'h00004;
    step(3);
    check("clredge_pre", led_red, 18'h004);
    sw = 18'h10044;
    step();
    sw = 18'h00044;
    step(3);
    check("clredge_pending", led_red, 18'h040);
    step(2);
    check("clredge_pending_held", led_red, 18'h040);

    // Reset in the middle of a hold
    sw = 18'h20044;
    wait_grant("midrst_g6", 10);
    check("midrst_g6_id", led_green, 9'h140);
    step();
    rst_n = 1'b0;
    step();
    check("midrst_green", led_green, 9'h000);
    check("midrst_red",   led_red,   18'h000);
    check("midrst_seg",   seg_n,     disp(H0, H0, BL, BL));
    rst_n = 1'b1;
    wait_grant("postrst", 10);
    check("postrst_id",  led_green, 9'h104);
    check("postrst_seg", seg_n,     disp(H0, H1, H2, H2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_request_scheduler.md
# display_request_scheduler

Round-robin scheduler that shares the board's seven-segment display and LED resources among eight switch requesters. A rising edge on request switch k queues a request, and granted requesters own digit 0 for a fixed hold window. Switch and LED activity is sequenced through a small FSM rather than mapped combinationally. It sits at top level between the board switches and the seven-segment/LED outputs.

## Interface
- HOLD_CYCLES, 50_000_000, clock cycles a grant is held (≥2)
- DEBOUNCE_CYCLES, 1_000_000, cycles a synchronized switch must be stable (used only with debounce enabled)
- CLOCK_50_I  input  1  system clock, 50 MHz
- RESETN_I  input  1  synchronous, active-low reset
- SWITCH_I  input  18  [7:0] request lines, [16] clear-pending, [17] scheduler enable
- SEVEN_SEGMENT_N_O  output  8×7  active-low segments, digits 0–7
- LED_RED_O  output  18  [7:0] pending mask, [17:8] tied 0
- LED_GREEN_O  output  9  [7:0] one-hot grant, [8] busy

## Operation
- Each SWITCH_I bit passes through a 2-FF synchronizer; request edges are detected against a previous-value register.
- Pending set: rising edge on synchronized request k sets pending[k].
- Clear: while synchronized SWITCH_I[16]=1, pending is cleared every cycle. A same-cycle set wins over the clear. An active grant is not aborted.
- FSM states: S_IDLE, S_GRANT, S_HOLD, S_RELEASE.
  - S_IDLE → S_GRANT when enable=1 and pending≠0. The winner is the first pending index searching upward from last_grant+1, wrapping mod 8.
  - S_GRANT (1 cycle): grant is loaded one-hot, pending[winner] is cleared (unless re-set this cycle), last_grant is updated, and service_count is incremented. Then → S_HOLD.
  - S_HOLD: hold counter runs HOLD_CYCLES-1 cycles. Then → S_RELEASE.
  - S_RELEASE (1 cycle): grant is cleared. Then → S_IDLE.
- Enable dropped mid-grant: the grant completes normally, and no new grant is issued.
- service_count is 8 bits and wraps 0xFF→0x00.
- Display:
  - Digit 0: hex of the granted index while granted, else blank (7'h7F).
  - Digit 1: hex of last_grant once any grant has occurred, else blank.
  - Digits 3:2: service_count in hex.
  - Digits 7:4: blank.
- Reset values:
  - pending=0, grant=0, busy=0.
  - last_grant=7, so the first search starts at index 0.
  - service_count=0, state=S_IDLE, synchronizers and edge registers 0.
  - Digits 0, 1 and 4–7 blank; digits 2 and 3 show 7'h40 ("0").
  - LED_RED_O=0, LED_GREEN_O=0.
- Reset asserted mid-operation returns every register to its reset value on the next clock edge.

## Timing
- Edge latency: a switch change sampled at edge n sets its pending LED after edge n+2 (2 sync stages, with edge detection in the same cycle as the pending update).
- Grant timing: if pending becomes nonzero at cycle t in S_IDLE, grant and digit 0 are valid from t+1.
  - Grant stays high for exactly HOLD_CYCLES cycles (S_GRANT plus HOLD_CYCLES-1 in S_HOLD) and drops in S_RELEASE.
  - busy is high in S_GRANT, S_HOLD and S_RELEASE.
- Back-to-back grants are separated by 2 cycles with grant low (S_RELEASE, S_IDLE).
- All LED outputs are registered. Seven-segment outputs are combinational decodes of registers, with no added latency.

## Configuration
- DISPLAY_SCHED_DEBOUNCE_EN defined: each synchronized switch feeds a per-bit stable counter. The debounced value updates only after DEBOUNCE_CYCLES consecutive equal samples, so edge latency grows by DEBOUNCE_CYCLES.
- Undefined: debounce logic is absent, and the synchronizer output drives edge detection directly.

## Structure
- Package display_scheduler_pkg holds:
  - the state enum type;
  - SEG_BLANK = 7'h7F;
  - the NUM_REQ = 8 constant.
- Sub-module convert_hex_to_seven_segment: a 4-bit hex to active-low 7-segment decoder, instantiated once per driven digit.

## Test plan
Run with HOLD_CYCLES=4 and debounce off unless noted.
- Reset: hold RESETN_I=0 for 3 cycles with arbitrary switches → all LEDs 0; digits 0, 1 and 4–7 show 7'h7F; digits 2 and 3 show 7'h40.
- Single request: SWITCH_I=18'h20000, then 18'h20004 → pending[2] set; grant 8'h04 for exactly 4 cycles; digit 0 shows "2"; count=1; digit 1 shows "2" afterwards.
- Round-robin: enable=1, SWITCH_I[7:0] goes 0→8'h83 in one cycle → grants issue in order 0, 1, 7; each grant is 4 cycles high with a 2-cycle gap; count=3.
- Enable/clear: requests on 3 and 5 with enable=0 → no grant and pending=8'h28. Pulse SWITCH_I[16] → pending=0. Enable=1 → no grant.
- Simultaneous events: request 1 re-edges during its own S_GRANT cycle → pending[1] stays set and is re-granted after the other pending requests. Clear asserted on the same cycle as a new edge → that bit stays pending.
- Reset mid-hold: assert RESETN_I during S_HOLD → on the next edge, grant=0, busy=0, count=0 and state returns to S_IDLE. After release, the first grant goes to the lowest pending index.
